// File: rtl/zap_predecode_copro_arb.sv
// Coprocessor arbitration stage for the predecode pipeline.
// Spots coprocessor instructions, checks whether the addressed coprocessor
// may be used, waits for the downstream pipeline to empty, then hands the
// word to the coprocessor and stalls until it reports done or error, or
// until the timeout expires. Refused or failed accesses turn into an
// undefined-instruction trap on the instruction itself.
module zap_predecode_copro_arb #(
   parameter logic [15:0] CP_PRESENT = 16'h8000,
   parameter logic [15:0] CP_USER_OK = 16'h0000,
   parameter logic [31:0] TIMEOUT    = 32'd256
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [34:0] i_instruction,
   input  logic        i_valid,
   input  logic        i_cpsr_ff_t,
   input  logic [4:0]  i_cpsr_ff_mode,
   input  logic        i_irq,
   input  logic        i_fiq,
   input  logic        i_clear_from_writeback,
   input  logic        i_data_stall,
   input  logic        i_clear_from_alu,
   input  logic        i_stall_from_shifter,
   input  logic        i_stall_from_issue,
   input  logic        i_clear_from_decode,
   input  logic        i_pipeline_dav,
   input  logic [15:0] i_copro_done,
   input  logic [15:0] i_copro_err,
   output logic        o_irq,
   output logic        o_fiq,
   output logic [34:0] o_instruction,
   output logic        o_valid,
   output logic        o_und,
   output logic        o_stall_from_decode,
   output logic [15:0] o_copro_dav_nxt,
   output logic [31:0] o_copro_word_nxt
);

   localparam logic [4:0]  USR      = 5'b10000;
   // Last counter value allowed in BUSY; reaching it ends the access.
   localparam logic [15:0] TMO_LAST = TIMEOUT[15:0] - 16'd1;

   typedef enum logic [1:0] {IDLE, DRAIN, BUSY, UNDEF} state_t;

   state_t      state, state_adv, state_nxt;
   logic [15:0] dav,   dav_adv,   dav_nxt;
   logic [31:0] word,  word_adv,  word_nxt;
   logic [15:0] cnt,   cnt_adv,   cnt_nxt;
   logic [3:0]  cp,    cp_adv,    cp_nxt;
   logic        und,   und_adv,   und_nxt;

   logic [3:0]  cp_num;
   logic        is_copro;
   logic        permit;
   logic        clr;
   logic        hold;
   logic        chan_done;
   logic        chan_err;

   assign cp_num   = i_instruction[11:8];
   assign is_copro = !i_cpsr_ff_t && (i_instruction[34:32] == 3'd0) && i_valid &&
                     ((i_instruction[27:24] == 4'b1110) || (i_instruction[27:25] == 3'b110));
   assign permit   = CP_PRESENT[cp_num] && ((i_cpsr_ff_mode != USR) || CP_USER_OK[cp_num]);

   // Flushes beat stalls; an alu flush is deferred while memory stalls, and
   // a decode flush waits for every downstream stall to go away.
   assign clr  = i_clear_from_writeback ||
                 (i_clear_from_alu && !i_data_stall) ||
                 (i_clear_from_decode && !i_data_stall && !i_stall_from_shifter && !i_stall_from_issue);
   assign hold = !clr && (i_data_stall || i_stall_from_shifter || i_stall_from_issue);

   // Only the channel that owns the current access is listened to.
   assign chan_done = i_copro_done[cp];
   assign chan_err  = i_copro_err[cp];

   // State machine transition assuming the pipeline advances this cycle.
   always_comb begin
      state_adv = state;
      dav_adv   = dav;
      word_adv  = word;
      cnt_adv   = cnt;
      cp_adv    = cp;
      und_adv   = und;
      case (state)
         IDLE: begin
            if (is_copro && permit) begin
               if (i_pipeline_dav) begin
                  state_adv = DRAIN;
               end else begin
                  state_adv = BUSY;
                  dav_adv   = 16'd1 << cp_num;
                  word_adv  = i_instruction[31:0];
                  cnt_adv   = 16'd0;
                  cp_adv    = cp_num;
               end
            end
         end
         DRAIN: begin
            // Upstream is stalled, so the instruction on the input is still ours.
            if (!i_pipeline_dav) begin
               state_adv = BUSY;
               dav_adv   = 16'd1 << cp_num;
               word_adv  = i_instruction[31:0];
               cnt_adv   = 16'd0;
               cp_adv    = cp_num;
            end
         end
         BUSY: begin
            // Error or timeout takes precedence over a simultaneous done.
            if (chan_err || (cnt == TMO_LAST)) begin
               state_adv = UNDEF;
               dav_adv   = 16'd0;
               word_adv  = 16'd0;
               und_adv   = 1'b1;
            end else if (chan_done) begin
               state_adv = IDLE;
               dav_adv   = 16'd0;
               word_adv  = 32'd0;
            end else if (cnt != 16'hFFFF) begin
               cnt_adv = cnt + 16'd1;
            end
         end
         UNDEF: begin
            state_adv = IDLE;
            und_adv   = 1'b0;
            cnt_adv   = 16'd0;
         end
         default: state_adv = IDLE;
      endcase
   end

   // Apply flush / hold priority on top of the advancing transition.
   always_comb begin
      state_nxt = state_adv;
      dav_nxt   = dav_adv;
      word_nxt  = word_adv;
      cnt_nxt   = cnt_adv;
      cp_nxt    = cp_adv;
      und_nxt   = und_adv;
      if (!i_reset_n || clr) begin
         state_nxt = IDLE;
         dav_nxt   = 16'd0;
         word_nxt  = 32'd0;
         cnt_nxt   = 16'd0;
         cp_nxt    = 4'd0;
         und_nxt   = 1'b0;
      end else if (hold) begin
         state_nxt = state;
         dav_nxt   = dav;
         word_nxt  = word;
         cnt_nxt   = cnt;
         cp_nxt    = cp;
         und_nxt   = und;
      end
   end

   // Arbitration state registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
         dav   <= 16'd0;
         word  <= 32'd0;
         cnt   <= 16'd0;
         cp    <= 4'd0;
         und   <= 1'b0;
      end else begin
         state <= state_nxt;
         dav   <= dav_nxt;
         word  <= word_nxt;
         cnt   <= cnt_nxt;
         cp    <= cp_nxt;
         und   <= und_nxt;
      end
   end

   assign o_copro_dav_nxt  = dav_nxt;
   assign o_copro_word_nxt = word_nxt;
   assign o_instruction    = i_instruction;

   // Pipeline-facing outputs: transparent unless an access is in flight.
   always_comb begin
      o_valid             = i_valid;
      o_und               = 1'b0;
      o_stall_from_decode = 1'b0;
      o_irq               = i_irq;
      o_fiq               = i_fiq;
      if (i_reset_n) begin
         case (state)
            IDLE: begin
               if (is_copro) begin
                  if (permit) begin
                     o_stall_from_decode = 1'b1;
                     o_valid             = 1'b0;
                     o_irq               = 1'b0;
                     o_fiq               = 1'b0;
                  end else begin
                     o_und = 1'b1;
                  end
               end
            end
            DRAIN: begin
               o_stall_from_decode = 1'b1;
               o_valid             = 1'b0;
               o_irq               = 1'b0;
               o_fiq               = 1'b0;
            end
            BUSY: begin
               // Stall drops in the very cycle the owning channel completes.
               o_stall_from_decode = !(chan_done && !chan_err && !hold);
               o_valid             = 1'b0;
               o_irq               = 1'b0;
               o_fiq               = 1'b0;
            end
            UNDEF: begin
               o_und = und && i_valid;
               o_irq = 1'b0;
               o_fiq = 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_zap_predecode_copro_arb.sv
// Scoreboard bench for the coprocessor arbitration stage.
module tb_zap_predecode_copro_arb;

   localparam logic [31:0] MRC15 = 32'hEE110F10;
   localparam logic [31:0] MCR15 = 32'hEE010F10;
   localparam logic [31:0] CDP15 = 32'hEE000F00;
   localparam logic [31:0] LDC15 = 32'hED900F00;
   localparam logic [31:0] MRC14 = 32'hEE110E10;
   localparam logic [31:0] MOVI  = 32'hE3A00001;
   localparam logic [4:0]  SVC   = 5'b10011;
   localparam logic [4:0]  USRM  = 5'b10000;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic [34:0] i_instruction;
   logic        i_valid, i_cpsr_ff_t;
   logic [4:0]  i_cpsr_ff_mode;
   logic        i_irq, i_fiq;
   logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
   logic        i_stall_from_shifter, i_stall_from_issue, i_clear_from_decode;
   logic        i_pipeline_dav;
   logic [15:0] i_copro_done, i_copro_err;
   logic        o_irq, o_fiq, o_valid, o_und, o_stall_from_decode;
   logic [34:0] o_instruction;
   logic [15:0] o_copro_dav_nxt;
   logic [31:0] o_copro_word_nxt;

   typedef struct {
      logic [34:0] instr;
      logic        v, u, s, irq;
      logic [15:0] dav;
      logic [31:0] word;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   zap_predecode_copro_arb #(
      .CP_PRESENT(16'h8000), .CP_USER_OK(16'h0000), .TIMEOUT(32'd8)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_instruction(i_instruction),
      .i_valid(i_valid), .i_cpsr_ff_t(i_cpsr_ff_t), .i_cpsr_ff_mode(i_cpsr_ff_mode),
      .i_irq(i_irq), .i_fiq(i_fiq),
      .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
      .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
      .i_stall_from_issue(i_stall_from_issue), .i_clear_from_decode(i_clear_from_decode),
      .i_pipeline_dav(i_pipeline_dav), .i_copro_done(i_copro_done), .i_copro_err(i_copro_err),
      .o_irq(o_irq), .o_fiq(o_fiq), .o_instruction(o_instruction), .o_valid(o_valid),
      .o_und(o_und), .o_stall_from_decode(o_stall_from_decode),
      .o_copro_dav_nxt(o_copro_dav_nxt), .o_copro_word_nxt(o_copro_word_nxt)
   );

   task automatic chk(input string nm, input int cyc, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @item %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared away from the clock edge.
   initial begin
      int n = 0;
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n++;
            chk("instr", n, o_instruction, e.instr);
            chk("valid", n, 35'(o_valid), 35'(e.v));
            chk("und",   n, 35'(o_und), 35'(e.u));
            chk("stall", n, 35'(o_stall_from_decode), 35'(e.s));
            chk("irq",   n, 35'(o_irq), 35'(e.irq));
            chk("fiq",   n, 35'(o_fiq), 35'(e.irq));
            chk("dav",   n, 35'(o_copro_dav_nxt), 35'(e.dav));
            chk("word",  n, 35'(o_copro_word_nxt), 35'(e.word));
         end
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic ex(input logic v, u, s, irq, input logic [15:0] dav, input logic [31:0] word);
      exp_t e;
      e.instr = i_instruction;
      e.v = v; e.u = u; e.s = s; e.irq = irq; e.dav = dav; e.word = word;
      q.push_back(e);
   endtask

   task automatic ins(input logic [31:0] w);
      i_instruction = {3'b000, w};
   endtask

   initial begin
      i_reset_n = 1'b0; ins(MRC15); i_valid = 1'b1; i_cpsr_ff_t = 1'b0;
      i_cpsr_ff_mode = SVC; i_irq = 1'b1; i_fiq = 1'b1;
      i_clear_from_writeback = 1'b0; i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
      i_stall_from_shifter = 1'b0; i_stall_from_issue = 1'b0; i_clear_from_decode = 1'b0;
      i_pipeline_dav = 1'b0; i_copro_done = 16'h0; i_copro_err = 16'h0;

      // Reset: transparent even with a copro instruction present
      cyc(); ex(1,0,0,1,16'h0,32'h0);
      cyc(); ex(1,0,0,1,16'h0,32'h0);
      cyc(); i_reset_n = 1'b1; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // MRC p15 in SVC, pipeline empty, done after 3 BUSY cycles
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_copro_done = 16'h4000; ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_copro_done = 16'h8000; ex(0,0,0,0,16'h0,32'h0);
      cyc(); i_copro_done = 16'h0; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Refused / non-copro cases in IDLE
      cyc(); ins(MCR15); i_cpsr_ff_mode = USRM; ex(1,1,0,1,16'h0,32'h0);
      cyc(); ins(MOVI); ex(1,0,0,1,16'h0,32'h0);
      cyc(); ins(MCR15); i_valid = 1'b0; ex(0,0,0,1,16'h0,32'h0);
      cyc(); i_valid = 1'b1; i_cpsr_ff_mode = SVC; ins(MRC14); ex(1,1,0,1,16'h0,32'h0);
      cyc(); ins(MRC15); i_cpsr_ff_t = 1'b1; ex(1,0,0,1,16'h0,32'h0);
      cyc(); i_cpsr_ff_t = 1'b0; i_instruction = {3'b001, MRC15}; ex(1,0,0,1,16'h0,32'h0);

      // CDP with busy pipeline: drain, then err+done together -> undefined
      cyc(); ins(CDP15); i_pipeline_dav = 1'b1; ex(0,0,1,0,16'h0,32'h0);
      for (int k = 0; k < 3; k++) begin cyc(); ex(0,0,1,0,16'h0,32'h0); end
      cyc(); i_pipeline_dav = 1'b0; ex(0,0,1,0,16'h8000,CDP15);
      cyc(); i_copro_done = 16'h8000; i_copro_err = 16'h8000; ex(0,0,1,0,16'h0,32'h0);
      cyc(); i_copro_done = 16'h0; i_copro_err = 16'h0; ex(1,1,0,0,16'h0,32'h0);
      cyc(); ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Timeout: 8 BUSY cycles, then one UNDEF cycle
      cyc(); ins(LDC15); ex(0,0,1,0,16'h8000,LDC15);
      for (int k = 0; k < 7; k++) begin cyc(); ex(0,0,1,0,16'h8000,LDC15); end
      cyc(); ex(0,0,1,0,16'h0,32'h0);
      cyc(); ex(1,1,0,0,16'h0,32'h0);
      cyc(); ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Writeback flush together with done
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_clear_from_writeback = 1'b1; i_copro_done = 16'h8000; ex(0,0,0,0,16'h0,32'h0);
      cyc(); i_clear_from_writeback = 1'b0; i_copro_done = 16'h0; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Alu flush in BUSY
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_clear_from_alu = 1'b1; ex(0,0,1,0,16'h0,32'h0);
      cyc(); i_clear_from_alu = 1'b0; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Data stall freezes the counter (and masks a done)
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      for (int k = 0; k < 4; k++) begin cyc(); ex(0,0,1,0,16'h8000,MRC15); end
      for (int k = 0; k < 5; k++) begin
         cyc(); i_data_stall = 1'b1; i_copro_done = (k == 2) ? 16'h8000 : 16'h0;
         ex(0,0,1,0,16'h8000,MRC15);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(); i_data_stall = 1'b0; i_copro_done = 16'h0; ex(0,0,1,0,16'h8000,MRC15);
      end
      cyc(); ex(0,0,1,0,16'h0,32'h0);
      cyc(); ex(1,1,0,0,16'h0,32'h0);
      cyc(); ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Reset in the middle of BUSY aborts the access
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_reset_n = 1'b0; ex(1,0,0,1,16'h0,32'h0);
      cyc(); i_reset_n = 1'b1; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);
      cyc(); ins(MRC15); ex(0,0,1,0,16'h8000,MRC15);
      cyc(); i_copro_done = 16'h8000; ex(0,0,0,0,16'h0,32'h0);
      cyc(); i_copro_done = 16'h0; ins(MOVI); ex(1,0,0,1,16'h0,32'h0);

      // Let the monitor drain, bounded
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge i_clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
